music_box_recorder: RTL and testbench

MUSIC_BOX_RECORDER -- requirements
Module: music_box_recorder

---
 rtl/music_box_pkg.sv | 18 +
 rtl/music_box_recorder_sample_buffer.sv | 70 +++++++
 rtl/music_box_recorder.sv | 130 +++++++++++++
 tb/tb_music_box_recorder.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_box_pkg.sv
// Shared definitions for the music box recorder: FSM states, SDRAM address width
// and the pad byte used to complete a half-filled packed word.
package music_box_pkg;

  localparam int ADDR_W = 25;
  localparam logic [7:0] PAD_SAMPLE = 8'h80;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ARM      = 4'd1,
    CAPTURE  = 4'd2,
    ISSUE    = 4'd3,
    WAIT_ACK = 4'd4,
    FLUSH    = 4'd5,
    DONE     = 4'd6
  } rec_state_t;

endpackage

// File: rtl/music_box_recorder_sample_buffer.sv
// Packs incoming 8-bit samples into 16-bit words, parks one sample while a write
// is in flight and counts samples dropped because that parking slot was full.
module recorder_sample_buffer
  import music_box_pkg::*;
#(
  parameter int PACK = 1
) (
  input  logic        clock_50Mhz,
  input  logic        reset,
  input  logic        clear,
  input  logic        capture_en,
  input  logic        hold_en,
  input  logic        pad,
  input  logic        strobe,
  input  logic [7:0]  sample,
  output logic [15:0] word,
  output logic        word_ready,
  output logic        half_full,
  output logic [15:0] overrun
);

  logic       hold_valid;
  logic [7:0] hold_data;
  logic       src_valid;
  logic [7:0] src;

  // A parked sample is always older than a fresh strobe, so it is consumed first.
  assign src_valid  = hold_valid || strobe;
  assign src        = hold_valid ? hold_data : sample;
  assign word_ready = capture_en && src_valid && ((PACK == 1) || half_full);

  always_ff @(posedge clock_50Mhz) begin
    if (reset || clear) begin
      word       <= '0;
      half_full  <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      overrun    <= '0;
    end else if (capture_en) begin
      if (hold_valid) begin
        hold_valid <= strobe;
        if (strobe) hold_data <= sample;
      end
      if (src_valid) begin
        if (PACK == 1) begin
          word <= {8'h00, src};
        end else if (!half_full) begin
          word[7:0] <= src;
          half_full <= 1'b1;
        end else begin
          word[15:8] <= src;
          half_full  <= 1'b0;
        end
      end
    end else if (hold_en) begin
      if (strobe) begin
        if (!hold_valid) begin
          hold_valid <= 1'b1;
          hold_data  <= sample;
        end else if (overrun != 16'hFFFF) begin
          overrun <= overrun + 16'd1;
        end
      end
    end else if (pad) begin
      word[15:8] <= PAD_SAMPLE;
      half_full  <= 1'b0;
    end
  end

endmodule

// File: rtl/music_box_recorder.sv
// Records a stream of 8-bit samples into one of several SDRAM slot regions,
// one 16-bit word per write, with a request/acknowledge handshake.
module music_box_recorder
  import music_box_pkg::*;
#(
  parameter logic [4:0] STATE_ID    = 5'd4,
  parameter int         NUM_SLOTS   = 4,
  parameter int         SLOT_STRIDE = 131072,
  parameter int         MAX_WORDS   = 110250,
  parameter int         PACK        = 1
) (
  input  logic                         clock_50Mhz,
  input  logic                         reset,
  input  logic [4:0]                   mainState,
  input  logic [$clog2(NUM_SLOTS)-1:0] slot_select,
  input  logic                         sample_strobe,
  input  logic [7:0]                   sample_in,
  input  logic                         stop_request,
  output logic [ADDR_W-1:0]            sdram_inputAddress,
  output logic [15:0]                  sdram_writeData,
  output logic                         sdram_isWriting,
  output logic                         sdram_inputValid,
  input  logic                         sdram_recievedCommand,
  input  logic                         sdram_isBusy,
  output logic                         stateComplete,
  output logic [17:0]                  recordedLength,
  output logic [15:0]                  overrunCount,
  output logic [31:0]                  debugString
);

  localparam logic [17:0] MAX_LEN = 18'(MAX_WORDS);

  rec_state_t        state;
  logic [ADDR_W-1:0] base;
  logic              stop_pending;
  logic              active;
  logic [17:0]       next_len;
  logic [15:0]       word;
  logic              word_ready;
  logic              half_full;
  logic              capture_en;
  logic              hold_en;
  logic              pad;
  logic              clear;

  assign active     = (mainState == STATE_ID);
  assign clear      = (state == ARM);
  assign capture_en = active && (state == CAPTURE) && !stop_request;
  assign hold_en    = active && ((state == ISSUE) || (state == WAIT_ACK));
  assign pad        = active && (state == FLUSH);
  assign next_len   = recordedLength + 18'd1;

  assign sdram_isWriting = sdram_inputValid;
  assign debugString     = {state, 10'b0, recordedLength};

  recorder_sample_buffer #(.PACK(PACK)) u_buffer (
    .clock_50Mhz(clock_50Mhz),
    .reset      (reset),
    .clear      (clear),
    .capture_en (capture_en),
    .hold_en    (hold_en),
    .pad        (pad),
    .strobe     (sample_strobe),
    .sample     (sample_in),
    .word       (word),
    .word_ready (word_ready),
    .half_full  (half_full),
    .overrun    (overrunCount)
  );

  // A stop seen mid-write is remembered so the in-flight word still completes.
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      state              <= IDLE;
      base               <= '0;
      stop_pending       <= 1'b0;
      recordedLength     <= '0;
      sdram_inputAddress <= '0;
      sdram_writeData    <= '0;
      sdram_inputValid   <= 1'b0;
      stateComplete      <= 1'b0;
    end else if (!active) begin
      state            <= IDLE;
      sdram_inputValid <= 1'b0;
      stateComplete    <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= ARM;
        ARM: begin
          base           <= ADDR_W'(slot_select) * ADDR_W'(SLOT_STRIDE);
          recordedLength <= '0;
          stop_pending   <= 1'b0;
          stateComplete  <= 1'b0;
          state          <= CAPTURE;
        end
        CAPTURE: begin
          if (stop_request) state <= half_full ? FLUSH : DONE;
          else if (word_ready) state <= ISSUE;
        end
        FLUSH: begin
          stop_pending <= 1'b1;
          state        <= ISSUE;
        end
        ISSUE: begin
          if (stop_request) stop_pending <= 1'b1;
          if (!sdram_isBusy) begin
            sdram_inputValid   <= 1'b1;
            sdram_inputAddress <= base + ADDR_W'(recordedLength);
            sdram_writeData    <= word;
            state              <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (stop_request) stop_pending <= 1'b1;
          if (sdram_recievedCommand) begin
            sdram_inputValid <= 1'b0;
            recordedLength   <= next_len;
            state <= (next_len == MAX_LEN || stop_pending || stop_request) ? DONE : CAPTURE;
          end
        end
        DONE: begin
          stateComplete    <= 1'b1;
          sdram_inputValid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_music_box_recorder.sv
// Scoreboard bench: two recorder instances (byte-per-word and packed) share the
// stimulus; an SDRAM responder acknowledges writes and pops expected words.
module tb_music_box_recorder;

  localparam int ACK_DELAY = 3;

  typedef struct {
    logic [24:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  main_a, main_b;
  logic [1:0]  slot_select;
  logic        sample_strobe;
  logic [7:0]  sample_in;
  logic        stop_request;
  logic        sdram_recievedCommand;
  logic        sdram_isBusy;
  logic        sel;
  logic        ack_hold;

  logic [24:0] a_addr, b_addr, addr_m;
  logic [15:0] a_data, b_data, data_m;
  logic        a_wr, b_wr, writing_m;
  logic        a_valid, b_valid, valid_m;
  logic        a_done, b_done, complete_m;
  logic [17:0] a_len, b_len, len_m;
  logic [15:0] a_ovr, b_ovr, ovr_m;
  logic [31:0] a_dbg, b_dbg, dbg_m;

  wr_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  always #5 clk = ~clk;

  music_box_recorder #(.MAX_WORDS(8), .PACK(1)) dut_a (
    .clock_50Mhz(clk), .reset(reset), .mainState(main_a), .slot_select(slot_select),
    .sample_strobe(sample_strobe), .sample_in(sample_in), .stop_request(stop_request),
    .sdram_inputAddress(a_addr), .sdram_writeData(a_data), .sdram_isWriting(a_wr),
    .sdram_inputValid(a_valid), .sdram_recievedCommand(sdram_recievedCommand),
    .sdram_isBusy(sdram_isBusy), .stateComplete(a_done), .recordedLength(a_len),
    .overrunCount(a_ovr), .debugString(a_dbg)
  );

  music_box_recorder #(.MAX_WORDS(8), .PACK(2)) dut_b (
    .clock_50Mhz(clk), .reset(reset), .mainState(main_b), .slot_select(slot_select),
    .sample_strobe(sample_strobe), .sample_in(sample_in), .stop_request(stop_request),
    .sdram_inputAddress(b_addr), .sdram_writeData(b_data), .sdram_isWriting(b_wr),
    .sdram_inputValid(b_valid), .sdram_recievedCommand(sdram_recievedCommand),
    .sdram_isBusy(sdram_isBusy), .stateComplete(b_done), .recordedLength(b_len),
    .overrunCount(b_ovr), .debugString(b_dbg)
  );

  always_comb begin
    addr_m     = sel ? b_addr  : a_addr;
    data_m     = sel ? b_data  : a_data;
    writing_m  = sel ? b_wr    : a_wr;
    valid_m    = sel ? b_valid : a_valid;
    complete_m = sel ? b_done  : a_done;
    len_m      = sel ? b_len   : a_len;
    ovr_m      = sel ? b_ovr   : a_ovr;
    dbg_m      = sel ? b_dbg   : a_dbg;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] s);
    @(negedge clk);
    sample_strobe = 1'b1;
    sample_in     = s;
    @(negedge clk);
    sample_strobe = 1'b0;
  endtask

  task automatic pushWrite(input logic [24:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic waitComplete(input string tag);
    int n = 0;
    while (!complete_m && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(complete_m), 32'd1);
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || valid_m) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (!valid_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(valid_m), 32'd1);
  endtask

  task automatic armA(input logic [1:0] slot);
    @(negedge clk);
    slot_select = slot;
    main_a      = 5'd4;
    repeat (2) @(negedge clk);
  endtask

  // SDRAM responder: acknowledges ACK_DELAY cycles into a request unless held off.
  initial begin : responder
    int  wait_cnt;
    logic prev_v;
    logic [24:0] lat_addr;
    logic [15:0] lat_data;
    wr_t e;
    sdram_recievedCommand = 1'b0;
    wait_cnt = 0;
    prev_v   = 1'b0;
    lat_addr = '0;
    lat_data = '0;
    forever begin
      @(negedge clk);
      if (sdram_recievedCommand) begin
        sdram_recievedCommand = 1'b0;
        wait_cnt = 0;
      end else if (valid_m) begin
        if (!prev_v) begin
          lat_addr = addr_m;
          lat_data = data_m;
        end else begin
          checkOutput("addr_stable", 32'(addr_m), 32'(lat_addr));
          checkOutput("data_stable", 32'(data_m), 32'(lat_data));
        end
        if (!ack_hold) begin
          wait_cnt++;
          if (wait_cnt >= ACK_DELAY) begin
            sdram_recievedCommand = 1'b1;
            checkOutput("is_writing", 32'(writing_m), 32'd1);
            checkOutput("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              checkOutput("wr_addr", 32'(addr_m), 32'(e.addr));
              checkOutput("wr_data", 32'(data_m), 32'(e.data));
            end
          end
        end
      end else begin
        wait_cnt = 0;
      end
      prev_v = valid_m;
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int vcount;
    logic [7:0] s;
    reset = 1'b1;
    main_a = 5'd4;
    main_b = 5'd0;
    slot_select = 2'd0;
    sample_strobe = 1'b0;
    sample_in = 8'h00;
    stop_request = 1'b0;
    sdram_isBusy = 1'b0;
    sel = 1'b0;
    ack_hold = 1'b0;

    // Reset dominates an active mainState.
    repeat (4) @(negedge clk);
    checkOutput("rst_valid", 32'(valid_m), 32'd0);
    checkOutput("rst_debug", dbg_m, 32'd0);
    checkOutput("rst_len", 32'(len_m), 32'd0);
    checkOutput("rst_addr", 32'(addr_m), 32'd0);
    reset  = 1'b1;
    main_a = 5'd0;
    @(negedge clk);
    reset = 1'b0;

    // Byte-per-word recording into slot 2 up to MAX_WORDS.
    armA(2'd2);
    for (int i = 0; i < 8; i++) begin
      s = 8'h10 + 8'(i * 7);
      pushWrite(25'd262144 + 25'(i), {8'h00, s});
      applyStimulus(s);
      repeat (10) @(negedge clk);
    end
    waitComplete("s1_complete");
    checkOutput("s1_len", 32'(len_m), 32'd8);
    checkOutput("s1_overrun", 32'(ovr_m), 32'd0);
    checkOutput("s1_debug", dbg_m, {4'd6, 10'd0, 18'd8});
    applyStimulus(8'hEE);
    repeat (8) @(negedge clk);
    checkOutput("s1_done_len", 32'(len_m), 32'd8);
    checkOutput("s1_done_valid", 32'(valid_m), 32'd0);
    checkOutput("s1_sb_empty", 32'(exp_q.size()), 32'd0);
    main_a = 5'd0;
    @(negedge clk);
    checkOutput("s1_leave", 32'(complete_m), 32'd0);

    // Packed recording with stop mid-word; the strobe coincident with stop is dropped.
    sel = 1'b1;
    slot_select = 2'd1;
    main_b = 5'd4;
    repeat (2) @(negedge clk);
    pushWrite(25'd131072, 16'h2211);
    pushWrite(25'd131073, 16'h8033);
    applyStimulus(8'h11);
    repeat (3) @(negedge clk);
    applyStimulus(8'h22);
    repeat (10) @(negedge clk);
    applyStimulus(8'h33);
    repeat (3) @(negedge clk);
    @(negedge clk);
    sample_strobe = 1'b1;
    sample_in = 8'h44;
    stop_request = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    waitComplete("s2_complete");
    waitDrain("s2_drain");
    checkOutput("s2_len", 32'(len_m), 32'd2);
    stop_request = 1'b0;
    main_b = 5'd0;
    @(negedge clk);
    sel = 1'b0;

    // Ack withheld across three strobe periods: one parked, two dropped.
    ack_hold = 1'b1;
    armA(2'd0);
    pushWrite(25'd0, 16'h005A);
    pushWrite(25'd1, 16'h0061);
    applyStimulus(8'h5A);
    applyStimulus(8'h61);
    repeat (3) @(negedge clk);
    applyStimulus(8'h62);
    repeat (3) @(negedge clk);
    applyStimulus(8'h63);
    repeat (2) @(negedge clk);
    checkOutput("s3_overrun_wait", 32'(ovr_m), 32'd2);
    checkOutput("s3_valid_wait", 32'(valid_m), 32'd1);
    checkOutput("s3_len_wait", 32'(len_m), 32'd0);
    ack_hold = 1'b0;
    waitDrain("s3_drain");
    repeat (3) @(negedge clk);
    stop_request = 1'b1;
    waitComplete("s3_complete");
    checkOutput("s3_len", 32'(len_m), 32'd2);
    checkOutput("s3_overrun", 32'(ovr_m), 32'd2);
    stop_request = 1'b0;
    main_a = 5'd0;
    @(negedge clk);

    // Busy controller holds back the request.
    sdram_isBusy = 1'b1;
    armA(2'd1);
    pushWrite(25'd131072, 16'h0077);
    applyStimulus(8'h77);
    vcount = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (valid_m) vcount++;
    end
    checkOutput("s4_no_valid_busy", 32'(vcount), 32'd0);
    sdram_isBusy = 1'b0;
    waitDrain("s4_drain");
    checkOutput("s4_len", 32'(len_m), 32'd1);

    // Leaving the recording state mid-handshake aborts to IDLE.
    ack_hold = 1'b1;
    applyStimulus(8'h78);
    waitValid("s5_valid");
    main_a = 5'd0;
    @(negedge clk);
    checkOutput("s5_valid_drop", 32'(valid_m), 32'd0);
    checkOutput("s5_complete", 32'(complete_m), 32'd0);
    checkOutput("s5_debug_idle", dbg_m, 32'd1);
    ack_hold = 1'b0;

    // Reset mid-write clears everything; re-entry restarts at the slot base.
    ack_hold = 1'b1;
    armA(2'd3);
    applyStimulus(8'h99);
    waitValid("s6_valid");
    reset = 1'b1;
    @(negedge clk);
    checkOutput("s6_valid", 32'(valid_m), 32'd0);
    checkOutput("s6_addr", 32'(addr_m), 32'd0);
    checkOutput("s6_data", 32'(data_m), 32'd0);
    checkOutput("s6_len", 32'(len_m), 32'd0);
    checkOutput("s6_debug", dbg_m, 32'd0);
    reset = 1'b0;
    ack_hold = 1'b0;
    repeat (3) @(negedge clk);
    pushWrite(25'd393216, 16'h00A5);
    applyStimulus(8'hA5);
    waitDrain("s6_drain");
    checkOutput("s6_reentry_len", 32'(len_m), 32'd1);
    main_a = 5'd0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
